workshop_downcounter: RTL

WORKSHOP_DOWNCOUNTER -- requirements
Module: workshop_downcounter

---
 rtl/workshop_pkg.sv | 11 +
 rtl/workshop_downcounter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/workshop_pkg.sv
// Shared definitions for the workshop down-counter: FSM state encoding and default width.
package workshop_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/workshop_downcounter.sv
// Loadable down-counter with start/stop run control and a single-cycle expiry pulse.
// Optional auto-reload on expiry when WORKSHOP_DOWNCOUNTER_AUTO_RELOAD_EN is defined.
module workshop_downcounter
    import workshop_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_s;
    logic             done_r;
    logic             done_s;
    logic [WIDTH-1:0] reload_s;

`ifdef WORKSHOP_DOWNCOUNTER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_r;
    logic [WIDTH-1:0] reload_nxt_s;

    // Reload value register, captured on every load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload_r <= ZERO_C;
        end else begin
            reload_r <= reload_nxt_s;
        end
    end

    // Next reload value: follows data_in on load, otherwise held.
    always_comb begin
        reload_nxt_s = reload_r;
        if (load) begin
            reload_nxt_s = data_in;
        end else begin
            reload_nxt_s = reload_r;
        end
    end

    assign reload_s = reload_r;
`else
    assign reload_s = ZERO_C;
`endif

    // State, count and done registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            count_r <= ZERO_C;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            done_r  <= done_s;
        end
    end

    // Next-state logic; load outranks stop, stop outranks start, start outranks decrement.
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        done_s  = 1'b0;
        if (load) begin
            count_s = data_in;
            state_s = IDLE;
        end else if (stop) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (count_r == ZERO_C) begin
                            done_s = 1'b1;
                        end else begin
                            state_s = RUN;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                RUN: begin
                    if (en && (count_r == ONE_C)) begin
                        done_s = 1'b1;
                        // A zero reload value means no reload: finish like a plain expiry.
                        if (reload_s != ZERO_C) begin
                            count_s = reload_s;
                        end else begin
                            count_s = ZERO_C;
                            state_s = IDLE;
                        end
                    end else if (en && (count_r != ZERO_C)) begin
                        count_s = count_r - ONE_C;
                    end else begin
                        count_s = count_r;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    assign data_out = count_r;
    assign busy     = (state_r == RUN);
    assign done     = done_r;
    assign zero     = (count_r == ZERO_C);

endmodule
